// File: rtl/vga_pixel_writer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : vga_pkg                                                       |
// | Description : Shared constants and state type for the VGA pixel writer.     |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package vga_pkg;

    localparam int unsigned c_cols        = 160;
    localparam int unsigned c_rows        = 120;
    localparam int unsigned c_color_depth = 3;
    localparam int unsigned c_pixels      = c_cols * c_rows;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vga_pixel_writer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : vga_pixel_writer_if                                           |
// | Description : Plot-command handshake and video-memory write port bundle.    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
interface vga_pixel_writer_if #(
    parameter int unsigned COLOR_DEPTH = 3,
    parameter int unsigned nX          = 8,
    parameter int unsigned nY          = 7,
    parameter int unsigned Mn          = 15
);

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [nX-1:0]          cmd_x;
    logic [nY-1:0]          cmd_y;
    logic [COLOR_DEPTH-1:0] cmd_color;
    logic [Mn-1:0]          mem_address;
    logic [COLOR_DEPTH-1:0] mem_data;
    logic                   mem_wren;

    // Command producer side
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_color,
        input  cmd_ready, mem_address, mem_data, mem_wren
    );

    // Pixel writer side
    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_color,
        output cmd_ready, mem_address, mem_data, mem_wren
    );

endinterface
`default_nettype wire

// File: rtl/vga_pixel_writer_addr_calc.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : pixel_address_calc                                            |
// | Description : Maps logical (x,y) to a linear address and a range flag.      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module pixel_address_calc #(
    parameter int unsigned nX   = 8,
    parameter int unsigned nY   = 7,
    parameter int unsigned Mn   = 15,
    parameter int unsigned COLS = 160,
    parameter int unsigned ROWS = 120
) (
    input  logic [nX-1:0] x,
    input  logic [nY-1:0] y,
    output logic [Mn-1:0] addr,
    output logic          in_range
);

    // Full Mn-bit product so in-range coordinates never truncate
    assign addr     = Mn'(y) * Mn'(COLS) + Mn'(x);
    assign in_range = (32'(x) < COLS) && (32'(y) < ROWS);

endmodule
`default_nettype wire

// File: rtl/vga_pixel_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : vga_pixel_writer                                              |
// | Description : Plot-command to video-memory write front end with optional    |
// |               full-screen clear engine (enabled by VGA_WRITER_CLEAR_EN).    |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module vga_pixel_writer
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_DEPTH = c_color_depth,
    parameter int unsigned nX          = 8,
    parameter int unsigned nY          = 7,
    parameter int unsigned Mn          = 15,
    parameter int unsigned COLS        = c_cols,
    parameter int unsigned ROWS        = c_rows
) (
    input  logic                   vga_clock,
    input  logic                   resetn,
    vga_pixel_writer_if.slave      bus,
    input  logic                   clear_req,
    input  logic [COLOR_DEPTH-1:0] clear_color,
    output logic                   busy,
    output logic                   oob_err
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [Mn-1:0]          r_mem_address;
    logic [Mn-1:0]          w_addr_nxt;
    logic [COLOR_DEPTH-1:0] r_mem_data;
    logic [COLOR_DEPTH-1:0] w_data_nxt;
    logic                   r_mem_wren;
    logic                   w_wren_nxt;
    logic                   r_oob_err;
    logic                   w_oob_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   w_cmd_ready;
    logic [Mn-1:0]          w_calc_addr;
    logic                   w_in_range;

    pixel_address_calc #(
        .nX   (nX),
        .nY   (nY),
        .Mn   (Mn),
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_addr_calc (
        .x        (bus.cmd_x),
        .y        (bus.cmd_y),
        .addr     (w_calc_addr),
        .in_range (w_in_range)
    );

`ifdef VGA_WRITER_CLEAR_EN
    localparam logic [Mn-1:0] c_last_addr = Mn'(COLS * ROWS - 1);

    logic [Mn-1:0]          r_clr_cnt;
    logic [Mn-1:0]          w_cnt_nxt;
    logic [COLOR_DEPTH-1:0] r_clr_color;
    logic [COLOR_DEPTH-1:0] w_color_nxt;
`else
    logic w_unused_clear;
    assign w_unused_clear = &{1'b0, clear_req, clear_color};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_mem_address;
        w_data_nxt  = r_mem_data;
        w_wren_nxt  = 1'b0;
        w_oob_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
        w_cmd_ready = 1'b1;
`ifdef VGA_WRITER_CLEAR_EN
        w_cnt_nxt   = r_clr_cnt;
        w_color_nxt = r_clr_color;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef VGA_WRITER_CLEAR_EN
                w_cmd_ready = !clear_req;
                // Address 0 is issued straight from IDLE so the fill lands one cycle after the request
                if (clear_req) begin
                    w_color_nxt = clear_color;
                    w_addr_nxt  = '0;
                    w_data_nxt  = clear_color;
                    w_wren_nxt  = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = Mn'(1);
                    w_state_nxt = (c_last_addr == '0) ? ST_IDLE : ST_CLEAR;
                end else
`endif
                if (bus.cmd_valid) begin
                    if (w_in_range) begin
                        w_addr_nxt = w_calc_addr;
                        w_data_nxt = bus.cmd_color;
                        w_wren_nxt = 1'b1;
                    end else begin
                        w_oob_nxt  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
`ifdef VGA_WRITER_CLEAR_EN
                w_cmd_ready = 1'b0;
                w_addr_nxt  = r_clr_cnt;
                w_data_nxt  = r_clr_color;
                w_wren_nxt  = 1'b1;
                w_busy_nxt  = 1'b1;
                w_cnt_nxt   = r_clr_cnt + Mn'(1);
                // Leave one cycle early so a command can be accepted while the last write is on the port
                if (r_clr_cnt == c_last_addr) begin
                    w_state_nxt = ST_IDLE;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_wren    <= 1'b0;
            r_oob_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_address <= w_addr_nxt;
            r_mem_data    <= w_data_nxt;
            r_mem_wren    <= w_wren_nxt;
            r_oob_err     <= w_oob_nxt;
            r_busy        <= w_busy_nxt;
        end
    end

`ifdef VGA_WRITER_CLEAR_EN
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
        end else begin
            r_clr_cnt   <= w_cnt_nxt;
            r_clr_color <= w_color_nxt;
        end
    end
`endif

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_data    = r_mem_data;
    assign bus.mem_wren    = r_mem_wren;
    assign busy            = r_busy;
    assign oob_err         = r_oob_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_vga_pixel_writer                                           |
// | Description : Directed self-checking bench; clear tests follow              |
// |               VGA_WRITER_CLEAR_EN, disabled-build tests otherwise.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_vga_pixel_writer;
    import vga_pkg::*;

    logic       vga_clock = 1'b0;
    logic       resetn    = 1'b0;
    logic       clear_req = 1'b0;
    logic [2:0] clear_color = 3'd0;
    logic       busy;
    logic       oob_err;
    int         checks = 0;
    int         errors = 0;

    vga_pixel_writer_if #(.COLOR_DEPTH(3), .nX(8), .nY(7), .Mn(15)) bus ();

    vga_pixel_writer #(
        .COLOR_DEPTH (3),
        .nX          (8),
        .nY          (7),
        .Mn          (15),
        .COLS        (160),
        .ROWS        (120)
    ) dut (
        .vga_clock   (vga_clock),
        .resetn      (resetn),
        .bus         (bus),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .busy        (busy),
        .oob_err     (oob_err)
    );

    always #5 vga_clock = ~vga_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge vga_clock);
    endtask

    task automatic set_cmd(input logic v, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        bus.cmd_valid = v;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_color = c;
    endtask

    initial begin
        int bad;
        set_cmd(1'b0, 8'd0, 7'd0, 3'd0);
        tick(); tick();
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wren", bus.mem_wren, 0);
        chk("rst_addr", bus.mem_address, 0);
        chk("rst_data", bus.mem_data, 0);
        chk("rst_oob", oob_err, 0);
        resetn = 1'b1;

        // Single plot (5,3) -> 3*160+5
        tick();
        set_cmd(1'b1, 8'd5, 7'd3, 3'b101);
        chk("plot_ready", bus.cmd_ready, 1);
        tick();
        set_cmd(1'b0, 8'd0, 7'd0, 3'd0);
        chk("plot_wren", bus.mem_wren, 1);
        chk("plot_addr", bus.mem_address, 485);
        chk("plot_data", bus.mem_data, 5);
        chk("plot_oob", oob_err, 0);
        tick();
        chk("plot_wren_off", bus.mem_wren, 0);
        chk("plot_data_hold", bus.mem_data, 5);

        // Back-to-back corners
        set_cmd(1'b1, 8'd0, 7'd0, 3'd1);
        chk("b2b_ready0", bus.cmd_ready, 1);
        tick();
        chk("b2b_wren0", bus.mem_wren, 1);
        chk("b2b_addr0", bus.mem_address, 0);
        chk("b2b_data0", bus.mem_data, 1);
        set_cmd(1'b1, 8'd159, 7'd119, 3'd7);
        chk("b2b_ready1", bus.cmd_ready, 1);
        tick();
        chk("b2b_wren1", bus.mem_wren, 1);
        chk("b2b_addr1", bus.mem_address, 19199);
        chk("b2b_data1", bus.mem_data, 7);
        set_cmd(1'b1, 8'd1, 7'd0, 3'd4);
        chk("b2b_ready2", bus.cmd_ready, 1);
        tick();
        chk("b2b_wren2", bus.mem_wren, 1);
        chk("b2b_addr2", bus.mem_address, 1);
        chk("b2b_data2", bus.mem_data, 4);

        // Out-of-range commands
        set_cmd(1'b1, 8'd160, 7'd0, 3'd3);
        tick();
        chk("oob_x_wren", bus.mem_wren, 0);
        chk("oob_x_err", oob_err, 1);
        set_cmd(1'b1, 8'd0, 7'd120, 3'd3);
        tick();
        chk("oob_y_wren", bus.mem_wren, 0);
        chk("oob_y_err", oob_err, 1);
        set_cmd(1'b0, 8'd0, 7'd0, 3'd0);
        tick();
        chk("oob_err_off", oob_err, 0);
        chk("oob_data_hold", bus.mem_data, 4);

`ifdef VGA_WRITER_CLEAR_EN
        // Clear wins over a simultaneous command; command (7,2) -> 327 lands right after
        clear_req   = 1'b1;
        clear_color = 3'b010;
        set_cmd(1'b1, 8'd7, 7'd2, 3'd6);
        chk("clr_req_ready", bus.cmd_ready, 0);
        chk("clr_req_busy", busy, 0);
        tick();
        clear_req = 1'b0;
        bad = 0;
        for (int k = 0; k < int'(c_pixels); k++) begin
            if (k > 0) tick();
            if (bus.mem_wren !== 1'b1 || bus.mem_address !== 15'(k) ||
                bus.mem_data !== 3'b010 || busy !== 1'b1 ||
                bus.cmd_ready !== (k == int'(c_pixels) - 1)) bad++;
        end
        chk("clr_seq_bad_cycles", bad, 0);
        chk("clr_end_ready", bus.cmd_ready, 1);
        chk("clr_last_addr", bus.mem_address, 19199);
        tick();
        set_cmd(1'b0, 8'd0, 7'd0, 3'd0);
        chk("clr_after_busy", busy, 0);
        chk("clr_after_wren", bus.mem_wren, 1);
        chk("clr_after_addr", bus.mem_address, 327);
        chk("clr_after_data", bus.mem_data, 6);
        tick();
        chk("clr_after_wren_off", bus.mem_wren, 0);

        // Reset at clear write 1000
        clear_req   = 1'b1;
        clear_color = 3'b101;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 1000; k++) tick();
        chk("abort_pre_addr", bus.mem_address, 1000);
        chk("abort_pre_wren", bus.mem_wren, 1);
        #2 resetn = 1'b0;
        #1;
        chk("abort_wren", bus.mem_wren, 0);
        chk("abort_addr", bus.mem_address, 0);
        chk("abort_data", bus.mem_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_oob", oob_err, 0);
        chk("abort_ready", bus.cmd_ready, 1);
        tick(); tick();
        resetn = 1'b1;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (bus.mem_wren !== 1'b0 || bus.cmd_ready !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("abort_quiet_bad_cycles", bad, 0);
`else
        // Clear disabled: request ignored, command (2,1) -> 162 still accepted
        clear_req   = 1'b1;
        clear_color = 3'd7;
        set_cmd(1'b1, 8'd2, 7'd1, 3'd3);
        chk("noclr_ready", bus.cmd_ready, 1);
        tick();
        clear_req = 1'b0;
        set_cmd(1'b0, 8'd0, 7'd0, 3'd0);
        chk("noclr_wren", bus.mem_wren, 1);
        chk("noclr_addr", bus.mem_address, 162);
        chk("noclr_data", bus.mem_data, 3);
        chk("noclr_busy", busy, 0);
        clear_req = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 3) clear_req = 1'b0;
            if (bus.mem_wren !== 1'b0 || busy !== 1'b0 || bus.cmd_ready !== 1'b1) bad++;
        end
        chk("noclr_quiet_bad_cycles", bad, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
